muldiv_issue: RTL and testbench
===============================

MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port ex_valid  in  1  EX-stage instruction valid.
REQ-004 SHALL have port ex_md_op  in  4  op code:
- 0000 mult, 0001 multu, 0010 div, 0011 divu, 1000 madd
- 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo
- any other code is a non-muldiv instruction.
REQ-005 SHALL have ports ex_rs, ex_rt  in  32 each  EX operands.
REQ-006 SHALL have ports md_busy  in  1, md_hi  in  32, md_lo  in  32  status and results from the multiply-divide unit.
REQ-007 SHALL have ports md_start  out  1, md_op  out  4, md_a  out  32, md_b  out  32  command to the multiply-divide unit.
REQ-008 SHALL have port stall  out  1  holds the IF/ID/EX pipeline stages.
REQ-009 SHALL have ports mf_valid  out  1, mf_data  out  32  mfhi/mflo result to the EX writeback path.
REQ-010 SHALL have port md_err  out  1  sticky protocol-error flag.
REQ-011 SHALL have port stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-012 SHALL implement FSM states IDLE, ARMED and BUSY.
REQ-013 A "long op" is mult, multu, madd, or div/divu with ex_rt!=0; an "md-class" op is any op in REQ-004 except "other".
REQ-014 In IDLE with md_busy=0, ex_valid=1 and a long op:
- md_start=1, md_op=ex_md_op, md_a=ex_rs, md_b=ex_rt for that cycle only;
- stall=0, so the issuing instruction proceeds;
- next state ARMED.
REQ-015 div/divu with ex_rt==0 SHALL issue nothing:
- md_start=0, no stall, state unchanged, HI/LO unchanged.
REQ-016 In IDLE with ex_valid=1 and mthi/mtlo:
- md_op=0100/0101 and md_a=ex_rs for one cycle;
- md_start=0, stall=0.
REQ-017 When not issuing per REQ-014 or REQ-016:
- md_op=1111, md_start=0, md_a=0, md_b=0;
- this prevents spurious HI/LO writes by the unit, which acts on mthi/mtlo codes regardless of start.
REQ-018 In IDLE with ex_valid=1 and mfhi/mflo:
- mf_valid=1, mf_data=md_hi or md_lo respectively (combinational);
- otherwise mf_valid=0, mf_data=0.
REQ-019 ARMED lasts exactly one cycle:
- md_busy=1 -> BUSY;
- md_busy=0 -> IDLE and md_err<=1.
REQ-020 BUSY -> IDLE on the first cycle md_busy=0; md_hi/md_lo are valid in that cycle.
REQ-021 In IDLE with md_busy=1 (unit still running after a controller-only reset) -> BUSY, no issue.
REQ-022 stall = ex_valid & md-class op & (state!=IDLE | md_busy); non-md-class ops never stall.
REQ-023 While stalled:
- md_start=0, md_op=1111, mf_valid=0;
- the stalled instruction is re-evaluated in IDLE on the cycle after return.
REQ-024 stall_cnt SHALL increment each cycle stall=1 and saturate at 16'hFFFF.
REQ-025 md_err SHALL be cleared only by reset.

Reset
REQ-026 While reset=0, regardless of clk:
- state=IDLE, md_err=0, stall_cnt=0;
- combinational outputs then follow REQ-017/018/022 (md_start=0, md_op=1111, stall=md_busy-dependent).
REQ-027 Reset mid-operation SHALL abandon ARMED/BUSY; no command is reissued.
REQ-028 After release, resynchronisation with a still-busy unit occurs per REQ-021.

Verification
REQ-029 The bench unit model SHALL hold busy for 4 cycles (mult/multu/madd) and 9 cycles (div/divu), rising one cycle after start.
REQ-030 mult rs=7 rt=-3, then mflo next cycle:
- start pulse 1 cycle; mflo stalls 5 cycles;
- then mf_valid=1, mf_data=32'hFFFFFFEB; stall_cnt=5.
REQ-031 div rs=100 rt=0:
- md_start never asserted, no stall;
- following mfhi returns the prior HI value.
REQ-032 mthi rs=32'hDEADBEEF while IDLE, then mfhi two cycles later:
- md_op=0100 for one cycle;
- mfhi returns 32'hDEADBEEF, no stall.
REQ-033 divu issued, then reset pulsed 2 cycles later while the model stays busy:
- stall_cnt=0;
- next mult stalls until model busy falls, then issues exactly one start.
REQ-034 Model ignores start (busy never rises):
- md_err=1 after the ARMED cycle, state IDLE, no stall;
- md_err remains 1 until reset.
REQ-035 Non-md add instruction during BUSY: stall=0.

Source files
------------

// File: rtl/muldiv_issue.sv
// rtl/muldiv_issue.sv - issue/stall controller between the EX stage and the multiply-divide unit
module muldiv_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [3:0]  ex_md_op,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall,
    output logic        mf_valid,
    output logic [31:0] mf_data,
    output logic        md_err,
    output logic [15:0] stall_cnt
);
    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MFHI  = 4'b0110;
    localparam logic [3:0] OP_MFLO  = 4'b0111;
    localparam logic [3:0] OP_MADD  = 4'b1000;
    localparam logic [3:0] OP_NONE  = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BUSY} state_t;
    state_t state;

    logic is_md, is_long, is_mt, is_mf, can_act, issue, mt_fire, mf_fire;

    always_comb begin
        is_md   = 1'b0;
        is_long = 1'b0;
        is_mt   = 1'b0;
        is_mf   = 1'b0;
        case (ex_md_op)
            OP_MULT, OP_MULTU, OP_MADD: begin
                is_md   = 1'b1;
                is_long = 1'b1;
            end
            // divide by zero is dropped: nothing is issued and HI/LO keep their values
            OP_DIV, OP_DIVU: begin
                is_md   = 1'b1;
                is_long = (ex_rt != 32'd0);
            end
            OP_MTHI, OP_MTLO: begin
                is_md = 1'b1;
                is_mt = 1'b1;
            end
            OP_MFHI, OP_MFLO: begin
                is_md = 1'b1;
                is_mf = 1'b1;
            end
            default: ;
        endcase
    end

    assign stall   = ex_valid & is_md & ((state != S_IDLE) | md_busy);
    assign can_act = ex_valid & (state == S_IDLE) & ~md_busy;
    assign issue   = can_act & is_long;
    assign mt_fire = can_act & is_mt;
    assign mf_fire = can_act & is_mf;

    // the unit writes HI/LO on mthi/mtlo codes even without start, so idle must drive a null code
    assign md_start = issue;
    assign md_op    = (issue | mt_fire) ? ex_md_op : OP_NONE;
    assign md_a     = (issue | mt_fire) ? ex_rs : 32'd0;
    assign md_b     = issue ? ex_rt : 32'd0;
    assign mf_valid = mf_fire;
    assign mf_data  = !mf_fire ? 32'd0 : (ex_md_op == OP_MFHI) ? md_hi : md_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            md_err    <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            case (state)
                S_IDLE: begin
                    if (md_busy)
                        state <= S_BUSY;
                    else if (issue)
                        state <= S_ARMED;
                end
                // the unit must acknowledge a start by raising busy on the very next cycle
                S_ARMED: begin
                    if (md_busy) begin
                        state <= S_BUSY;
                    end else begin
                        state  <= S_IDLE;
                        md_err <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!md_busy)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_issue.sv
// tb/tb_muldiv_issue.sv - randomized bench for muldiv_issue with unit model and reference model
module tb_muldiv_issue;
    logic        clk = 1'b0;
    logic        reset, ex_valid;
    logic [3:0]  ex_md_op;
    logic [31:0] ex_rs, ex_rt;
    logic        md_busy;
    logic [31:0] md_hi, md_lo;
    logic        md_start, stall, mf_valid, md_err;
    logic [3:0]  md_op;
    logic [31:0] md_a, md_b, mf_data;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    muldiv_issue dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_md_op(ex_md_op),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b), .stall(stall),
        .mf_valid(mf_valid), .mf_data(mf_data), .md_err(md_err), .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // multiply-divide unit model: busy rises one cycle after start, results land as busy falls
    logic        ignore_start = 1'b0;
    int          rem = 0;
    logic [31:0] u_hi = 32'd0, u_lo = 32'd0, pend_hi = 32'd0, pend_lo = 32'd0;
    assign md_busy = (rem != 0);
    assign md_hi   = u_hi;
    assign md_lo   = u_lo;

    always @(posedge clk) begin
        longint a, b, q, r;
        logic [63:0] p;
        a = $signed(md_a);
        b = $signed(md_b);
        p = 64'd0;
        if (md_op == 4'b0100) u_hi <= md_a;
        if (md_op == 4'b0101) u_lo <= md_a;
        if (rem != 0) begin
            rem <= rem - 1;
            if (rem == 1) begin
                u_hi <= pend_hi;
                u_lo <= pend_lo;
            end
        end else if (md_start && !ignore_start) begin
            case (md_op)
                4'b0000: p = a * b;
                4'b0001: p = {32'd0, md_a} * {32'd0, md_b};
                4'b1000: p = {u_hi, u_lo} + 64'(a * b);
                4'b0010: begin
                    q = a / b;
                    r = a % b;
                    p = {r[31:0], q[31:0]};
                end
                4'b0011: p = {md_a % md_b, md_a / md_b};
                default: p = 64'd0;
            endcase
            rem     <= (md_op == 4'b0010 || md_op == 4'b0011) ? 9 : 4;
            pend_hi <= p[63:32];
            pend_lo <= p[31:0];
        end
    end

    // reference: controller is occupied in a cycle iff it issued or saw the unit busy the cycle before
    logic        m_issued = 1'b0, m_busy = 1'b0, m_err = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    logic        e_stall = 1'b0, e_issue = 1'b0, held = 1'b0;
    int          n_start = 0;

    always @(negedge clk) begin
        logic occupied, md, lng, free, mt, mf;
        logic [3:0] op;
        op       = ex_md_op;
        md       = (op <= 4'd8);
        lng      = (op == 4'd0 || op == 4'd1 || op == 4'd8) ||
                   ((op == 4'd2 || op == 4'd3) && ex_rt != 32'd0);
        occupied = reset && (m_issued || m_busy);
        e_stall  = ex_valid && md && (occupied || md_busy);
        free     = ex_valid && !occupied && !md_busy;
        e_issue  = free && lng;
        mt       = free && (op == 4'd4 || op == 4'd5);
        mf       = free && (op == 4'd6 || op == 4'd7);
        check("stall", stall, e_stall);
        check("md_start", md_start, e_issue);
        check("md_op", md_op, (e_issue || mt) ? op : 4'hF);
        check("md_a", md_a, (e_issue || mt) ? ex_rs : 32'd0);
        check("md_b", md_b, e_issue ? ex_rt : 32'd0);
        check("mf_valid", mf_valid, mf);
        check("mf_data", mf_data, mf ? ((op == 4'd6) ? md_hi : md_lo) : 32'd0);
        check("md_err", md_err, reset && m_err);
        check("stall_cnt", stall_cnt, reset ? m_cnt : 16'd0);
        if (md_start) n_start++;
        held = stall;
    end

    always @(posedge clk) begin
        if (!reset) begin
            m_issued <= 1'b0;
            m_busy   <= 1'b0;
            m_err    <= 1'b0;
            m_cnt    <= 16'd0;
        end else begin
            if (m_issued && !md_busy) m_err <= 1'b1;
            if (e_stall && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            m_issued <= e_issue;
            m_busy   <= md_busy;
        end
    end

    logic        cap_mfv, cap_start;
    logic [31:0] cap_mfd;
    logic [3:0]  cap_op;

    task automatic run(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int stalls);
        ex_valid = 1'b1;
        ex_md_op = op;
        ex_rs    = rs;
        ex_rt    = rt;
        stalls   = 0;
        @(negedge clk);
        while (stall && stalls < 64) begin
            stalls++;
            @(negedge clk);
        end
        check("run_accept", stall, 1'b0);
        cap_mfv   = mf_valid;
        cap_mfd   = mf_data;
        cap_start = md_start;
        cap_op    = md_op;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        ex_md_op = 4'hF;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int s, n0;
        reset = 1'b0; ex_valid = 1'b0; ex_md_op = 4'hF; ex_rs = 32'd0; ex_rt = 32'd0;
        @(negedge clk);
        check("rst_err", md_err, 1'b0);
        check("rst_cnt", stall_cnt, 16'd0);
        check("rst_op", md_op, 4'hF);
        check("rst_start", md_start, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(1);

        n0 = n_start;
        run(4'b0000, 32'd7, 32'hFFFFFFFD, s);
        check("mult_nostall", s, 0);
        check("mult_start", cap_start, 1'b1);
        run(4'b0111, 32'd0, 32'd0, s);
        check("mflo_stalls", s, 5);
        check("mflo_valid", cap_mfv, 1'b1);
        check("mflo_data", cap_mfd, 32'hFFFFFFEB);
        check("mult_stall_cnt", stall_cnt, 16'd5);
        check("mult_one_start", n_start - n0, 1);

        run(4'b0100, 32'hDEADBEEF, 32'd0, s);
        check("mthi_op", cap_op, 4'b0100);
        check("mthi_nostall", s, 0);
        idle(1);
        run(4'b0110, 32'd0, 32'd0, s);
        check("mfhi_nostall", s, 0);
        check("mfhi_data", cap_mfd, 32'hDEADBEEF);

        n0 = n_start;
        run(4'b0010, 32'd100, 32'd0, s);
        check("div0_nostall", s, 0);
        check("div0_nostart", cap_start, 1'b0);
        run(4'b0110, 32'd0, 32'd0, s);
        check("div0_hi_kept", cap_mfd, 32'hDEADBEEF);
        check("div0_no_starts", n_start - n0, 0);

        run(4'b0000, 32'd3, 32'd5, s);
        run(4'b1010, 32'd1, 32'd2, s);
        check("add_armed_nostall", s, 0);
        idle(2);
        run(4'b1010, 32'd1, 32'd2, s);
        check("add_busy_nostall", s, 0);
        run(4'b0111, 32'd0, 32'd0, s);
        check("mult15_lo", cap_mfd, 32'd15);

        run(4'b0011, 32'd50, 32'd7, s);
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_cnt", stall_cnt, 16'd0);
        check("midrst_start", md_start, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        n0 = n_start;
        run(4'b0000, 32'd6, 32'd7, s);
        check("resync_stalls", s, 8);
        idle(12);
        check("resync_one_start", n_start - n0, 1);
        run(4'b0111, 32'd0, 32'd0, s);
        check("resync_lo", cap_mfd, 32'd42);

        check("pre_err_clear", md_err, 1'b0);
        ignore_start = 1'b1;
        run(4'b0000, 32'd2, 32'd3, s);
        check("noack_start", cap_start, 1'b1);
        idle(1);
        check("noack_err", md_err, 1'b1);
        run(4'b0111, 32'd0, 32'd0, s);
        check("noack_idle_nostall", s, 0);
        check("noack_lo_kept", cap_mfd, 32'd42);
        idle(5);
        check("noack_err_sticky", md_err, 1'b1);
        ignore_start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("err_cleared", md_err, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset        = ($urandom_range(0, 99) != 0);
            ignore_start = ($urandom_range(0, 31) == 0);
            if (!held) begin
                ex_valid = ($urandom_range(0, 3) != 0);
                ex_md_op = 4'($urandom_range(0, 15));
                ex_rs    = $urandom;
                ex_rt    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            end
        end
        ex_valid = 1'b0;
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
